// File: rtl/pc_branch_unit.sv
// Program counter with conditional jump/call, return stack and sticky stack error flags.
module pc_branch_unit #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned STACK_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable_i,
  input  logic                            load_i,
  input  logic                            call_i,
  input  logic                            ret_i,
  input  logic [2:0]                      cond_i,
  input  logic [ADDR_WIDTH-1:0]           target_i,
  input  logic                            flag_zero_i,
  input  logic                            flag_carry_i,
  input  logic                            flag_negative_i,
  output logic [ADDR_WIDTH-1:0]           pc_o,
  output logic                            taken_o,
  output logic [$clog2(STACK_DEPTH):0]    sp_o,
  output logic                            stack_overflow_o,
  output logic                            stack_underflow_o
);

  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
  localparam int unsigned SP_W  = IDX_W + 1;

  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

  logic                  cond_true_c;
  logic [ADDR_WIDTH-1:0] pc_nxt;
  logic [SP_W-1:0]       sp_nxt;
  logic                  taken_nxt;
  logic                  ovf_nxt;
  logic                  unf_nxt;
  logic                  push_c;
  logic [IDX_W-1:0]      push_idx;
  logic [IDX_W-1:0]      pop_idx;

  // Push goes to the first free slot; pop reads the most recently written one.
  assign push_idx = sp_o[IDX_W-1:0];
  assign pop_idx  = IDX_W'(sp_o - SP_W'(1));

  // Decode the condition select against the ALU flags.
  always_comb begin
    cond_true_c = 1'b0;
    case (cond_i)
      3'b000:  cond_true_c = 1'b1;
      3'b001:  cond_true_c = flag_zero_i;
      3'b010:  cond_true_c = ~flag_zero_i;
      3'b011:  cond_true_c = flag_carry_i;
      3'b100:  cond_true_c = ~flag_carry_i;
      3'b101:  cond_true_c = flag_negative_i;
      3'b110:  cond_true_c = ~flag_negative_i;
      default: cond_true_c = 1'b0;
    endcase
  end

  // Next-state selection with priority ret > call > load > enable > hold.
  always_comb begin
    pc_nxt    = pc_o;
    sp_nxt    = sp_o;
    taken_nxt = 1'b0;
    ovf_nxt   = stack_overflow_o;
    unf_nxt   = stack_underflow_o;
    push_c    = 1'b0;
    if (ret_i) begin
      if (sp_o != '0) begin
        pc_nxt    = stack_mem[pop_idx];
        sp_nxt    = sp_o - SP_W'(1);
        taken_nxt = 1'b1;
      end else begin
        unf_nxt = 1'b1;
      end
    end else if (call_i) begin
      if (cond_true_c) begin
        if (sp_o != SP_W'(STACK_DEPTH)) begin
          push_c    = 1'b1;
          pc_nxt    = target_i;
          sp_nxt    = sp_o + SP_W'(1);
          taken_nxt = 1'b1;
        end else begin
          ovf_nxt = 1'b1;
        end
      end
    end else if (load_i) begin
      if (cond_true_c) begin
        pc_nxt    = target_i;
        taken_nxt = 1'b1;
      end
    end else if (enable_i) begin
      pc_nxt = pc_o + ADDR_WIDTH'(1);
    end
  end

  // Architectural state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_o              <= RESET_VECTOR;
      sp_o              <= '0;
      taken_o           <= 1'b0;
      stack_overflow_o  <= 1'b0;
      stack_underflow_o <= 1'b0;
    end else begin
      pc_o              <= pc_nxt;
      sp_o              <= sp_nxt;
      taken_o           <= taken_nxt;
      stack_overflow_o  <= ovf_nxt;
      stack_underflow_o <= unf_nxt;
    end
  end

  // Return-address storage; contents are left stale across reset.
  always_ff @(posedge clk) begin
    if (reset && push_c) begin
      stack_mem[push_idx] <= pc_o;
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: driver pushes model expectations, monitor compares each cycle.
module tb_pc_branch_unit;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  RV    = 8'h00;

  logic       clk;
  logic       reset;
  logic       enable_i, load_i, call_i, ret_i;
  logic [2:0] cond_i;
  logic [7:0] target_i;
  logic       flag_zero_i, flag_carry_i, flag_negative_i;
  logic [7:0] pc_o;
  logic       taken_o;
  logic [2:0] sp_o;
  logic       stack_overflow_o, stack_underflow_o;

  pc_branch_unit #(
    .ADDR_WIDTH  (AW),
    .STACK_DEPTH (DEPTH),
    .RESET_VECTOR(RV)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable_i         (enable_i),
    .load_i           (load_i),
    .call_i           (call_i),
    .ret_i            (ret_i),
    .cond_i           (cond_i),
    .target_i         (target_i),
    .flag_zero_i      (flag_zero_i),
    .flag_carry_i     (flag_carry_i),
    .flag_negative_i  (flag_negative_i),
    .pc_o             (pc_o),
    .taken_o          (taken_o),
    .sp_o             (sp_o),
    .stack_overflow_o (stack_overflow_o),
    .stack_underflow_o(stack_underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] pc;
    logic       taken;
    logic [2:0] sp;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   stop   = 1'b0;

  // Reference model state: a plain integer PC and a queue used as the return stack.
  int   m_pc = 0;
  int   m_stack[$];
  bit   m_taken = 1'b0;
  bit   m_ovf = 1'b0;
  bit   m_unf = 1'b0;

  function automatic bit cond_ok(input logic [2:0] c, input logic z, input logic cy, input logic n);
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return cy;
      3'd4: return !cy;
      3'd5: return n;
      3'd6: return !n;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic e, input logic l, input logic c, input logic t,
                            input logic [2:0] cd, input logic [7:0] tg,
                            input logic fz, input logic fc, input logic fn);
    if (!r) begin
      m_pc = int'(RV);
      m_stack.delete();
      m_taken = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_taken = 1'b0;
      if (t) begin
        if (m_stack.size() > 0) begin
          m_pc = m_stack.pop_back();
          m_taken = 1'b1;
        end else begin
          m_unf = 1'b1;
        end
      end else if (c) begin
        if (cond_ok(cd, fz, fc, fn)) begin
          if (m_stack.size() < int'(DEPTH)) begin
            m_stack.push_back(m_pc);
            m_pc = int'(tg);
            m_taken = 1'b1;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end else if (l) begin
        if (cond_ok(cd, fz, fc, fn)) begin
          m_pc = int'(tg);
          m_taken = 1'b1;
        end
      end else if (e) begin
        m_pc = (m_pc + 1) % 256;
      end
    end
  endtask

  // Apply one cycle of inputs, queue the model's post-edge state, advance past the edge.
  task automatic drive(input logic r, input logic e, input logic l, input logic c, input logic t,
                       input logic [2:0] cd, input logic [7:0] tg,
                       input logic fz, input logic fc, input logic fn);
    exp_t x;
    reset = r; enable_i = e; load_i = l; call_i = c; ret_i = t;
    cond_i = cd; target_i = tg;
    flag_zero_i = fz; flag_carry_i = fc; flag_negative_i = fn;
    model_step(r, e, l, c, t, cd, tg, fz, fc, fn);
    x.pc    = 8'(m_pc);
    x.taken = m_taken;
    x.sp    = 3'(m_stack.size());
    x.ovf   = m_ovf;
    x.unf   = m_unf;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, req);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!stop) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
        end else begin
          e = exp_q.pop_front();
          check("pc_o",              32'(pc_o),              32'(e.pc));
          check("taken_o",           32'(taken_o),           32'(e.taken));
          check("sp_o",              32'(sp_o),              32'(e.sp));
          check("stack_overflow_o",  32'(stack_overflow_o),  32'(e.ovf));
          check("stack_underflow_o", 32'(stack_underflow_o), 32'(e.unf));
        end
      end
    end
  end

  initial begin
    // Reset, then three increments.
    drive(0, 0, 0, 0, 0, 3'd0, 8'h00, 0, 0, 0);
    drive(0, 1, 1, 1, 1, 3'd0, 8'hAA, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0, 3'd0, 8'h00, 0, 0, 0);

    // Conditional load on carry, taken then not taken with enable ignored.
    drive(1, 0, 1, 0, 0, 3'd0, 8'h05, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 3'd3, 8'h06, 0, 1, 0);
    drive(1, 1, 1, 0, 0, 3'd3, 8'h0A, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 3'd0, 8'h00, 0, 0, 0);

    // Call and return.
    drive(1, 0, 1, 0, 0, 3'd0, 8'h10, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 3'd0, 8'h40, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 3'd0, 8'h00, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 3'd0, 8'h00, 0, 0, 0);

    // Overflow on the fifth call, underflow on the fifth return.
    drive(1, 0, 1, 0, 0, 3'd0, 8'h20, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 1, 0, 3'd0, 8'(8'h30 + i), 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 1, 3'd0, 8'h00, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 3'd0, 8'h00, 0, 0, 0);

    // Wrap from 0xFF, then ret+call+enable together with one stacked entry.
    drive(0, 0, 0, 0, 0, 3'd0, 8'h00, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 3'd0, 8'h07, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 3'd0, 8'hFF, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 3'd0, 8'h00, 0, 0, 0);
    drive(1, 1, 0, 1, 1, 3'd0, 8'h99, 0, 0, 0);

    // Reset with sp=2 and both error flags set.
    drive(1, 0, 0, 0, 1, 3'd0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 1, 0, 3'd0, 8'(8'h60 + i), 0, 0, 0);
    drive(1, 0, 0, 0, 1, 3'd0, 8'h00, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 3'd0, 8'h00, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 3'd0, 8'h77, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 3'd0, 8'h00, 0, 0, 0);

    // Condition table sweep for call and load with random flags.
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        drive(1, 1, 0, 1, 0, 3'(c), 8'($urandom), f[0], f[1], f[2]);
        drive(1, 1, 1, 0, (f % 3) == 0, 3'(c), 8'($urandom), f[2], f[0], f[1]);
      end
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 59) != 0, 1'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            3'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    #1;
    stop = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, width of program counter, targets and stack entries.
REQ-002 Parameter STACK_DEPTH, default 4, number of return-address entries (power of two, >=2).
REQ-003 Parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
REQ-006 enable_i  input  1  increment request.
REQ-007 load_i  input  1  conditional jump request.
REQ-008 call_i  input  1  conditional call request.
REQ-009 ret_i  input  1  unconditional return request.
REQ-010 cond_i  input  3  condition select for load_i/call_i.
REQ-011 target_i  input  ADDR_WIDTH  jump/call destination.
REQ-012 flag_zero_i, flag_carry_i, flag_negative_i  input  1 each  ALU flags, sampled the same cycle as the request.
REQ-013 pc_o  output  ADDR_WIDTH  registered program counter.
REQ-014 taken_o  output  1  registered one-cycle pulse: previous cycle redirected the PC.
REQ-015 sp_o  output  $clog2(STACK_DEPTH)+1  occupied stack entries, 0..STACK_DEPTH.
REQ-016 stack_overflow_o, stack_underflow_o  output  1 each  sticky error flags.

Function
REQ-017 cond_i encoding SHALL be: 000 always, 001 Z, 010 !Z, 011 C, 100 !C, 101 N, 110 !N, 111 never.
REQ-018 Per cycle, exactly one action SHALL apply, priority ret_i > call_i > load_i > enable_i > hold.
REQ-019 ret_i, sp_o>0: pc_o <= top entry, sp_o decrements, taken_o <= 1 next cycle.
REQ-020 ret_i, sp_o==0: pc_o and sp_o unchanged, stack_underflow_o <= 1, taken_o <= 0.
REQ-021 call_i, condition true, sp_o<STACK_DEPTH: push current pc_o, pc_o <= target_i, sp_o increments, taken_o <= 1.
REQ-022 call_i, condition true, sp_o==STACK_DEPTH: no push, pc_o unchanged, stack_overflow_o <= 1, taken_o <= 0.
REQ-023 call_i or load_i with condition false: pc_o unchanged (no increment), taken_o <= 0; enable_i in the same cycle is ignored.
REQ-024 load_i, condition true: pc_o <= target_i, taken_o <= 1; stack untouched.
REQ-025 enable_i alone: pc_o <= pc_o + 1 modulo 2^ADDR_WIDTH (all-ones wraps to 0), taken_o <= 0.
REQ-026 No request: all state held, taken_o <= 0.
REQ-027 Error flags SHALL stay set until reset; they do not block later legal operations.
REQ-028 Latency: every action visible on pc_o/sp_o one clock after the requesting edge; no combinational input-to-output path.
REQ-029 Stack storage SHALL be LIFO; entry written by a push is the one returned by the next pop.

Reset
REQ-030 While reset==0 at a rising edge: pc_o <= RESET_VECTOR, sp_o <= 0, taken_o <= 0, both error flags <= 0; all requests ignored.
REQ-031 Reset mid-sequence (e.g. stack partly full) SHALL discard the stack; stack RAM contents need not be cleared.
REQ-032 First action after reset deassertion takes effect at the first rising edge with reset==1.

Verification
REQ-033 Reset, then 3 cycles enable_i -> pc_o 0x00,0x01,0x02,0x03; taken_o 0; sp_o 0.
REQ-034 pc_o=0x05, flag_carry_i=1, load_i, cond 011, target 0x06 -> pc_o 0x06, taken_o 1 one cycle; then flag_carry_i=0, same request with target 0x0A and enable_i=1 -> pc_o stays 0x06, taken_o 0.
REQ-035 pc_o=0x10, call_i cond 000 target 0x40; then ret_i -> pc_o 0x40, sp_o 1; then pc_o 0x10, sp_o 0, taken_o pulsed both times.
REQ-036 STACK_DEPTH=4: five calls cond 000 -> sp_o 4, fifth leaves pc_o unchanged, stack_overflow_o 1; four rets then fifth ret -> sp_o 0, stack_underflow_o 1, pc_o equals first call's return address.
REQ-037 pc_o=0xFF, enable_i -> pc_o 0x00; same cycle ret_i+call_i+enable_i with sp_o=1 -> return executed only.
REQ-038 sp_o=2 with both error flags set, reset=0 for one edge -> pc_o RESET_VECTOR, sp_o 0, flags 0, taken_o 0.
